timer_dev: RTL

TIMER_DEV -- requirements
Module: timer_dev

---
 rtl/timer_dev_if.sv | 11 +
 rtl/timer_dev.sv | 135 +++++++++++++
 2 files changed

// File: rtl/timer_dev_if.sv
// CPU data-port bundle for the timer: byte address, byte enables, write data
// and the combinational read-back path.
interface timer_dev_if;
  logic [31:0] addr;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output addr, output byteen, output wdata, input rdata);
  modport slave  (input addr, input byteen, input wdata, output rdata);
endinterface

// File: rtl/timer_dev.sv
// Memory-mapped down-counter with CTRL/PRESET/COUNT registers, one-shot or
// auto-reload operation and a masked interrupt.
module timer_dev #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic          clk,
  input  logic          reset,
  timer_dev_if.slave    bus,
  output logic          irq,
  output logic [1:0]    dbg_state_o
);

  // Bus handshake: a write happens on a rising edge when byteen != 0 and addr
  // is a word-aligned register address; reads are zero-latency and never stall.

  // dbg_state_o encoding follows declaration order: IDLE, LOAD, CNT, INT.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_e;

  localparam logic [29:0] CTRL_W   = BASE_ADDR[31:2];
  localparam logic [29:0] PRESET_W = BASE_ADDR[31:2] + 30'd1;
  localparam logic [29:0] COUNT_W  = BASE_ADDR[31:2] + 30'd2;

  state_e      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        flag_q, flag_d;
  logic        irq_q;

  logic [29:0] word;
  logic        wr_en, wr_ctrl, wr_preset;
  logic        en, auto_reload;

  assign word      = bus.addr[31:2];
  assign wr_en     = (bus.byteen != 4'b0000) && (bus.addr[1:0] == 2'b00);
  assign wr_ctrl   = wr_en && (word == CTRL_W);
  assign wr_preset = wr_en && (word == PRESET_W);

  assign en          = ctrl_q[0];
  assign auto_reload = (ctrl_q[2:1] == 2'b01);

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

  always_comb begin
    bus.rdata = 32'h0;
    if (word == CTRL_W)        bus.rdata = {28'h0, ctrl_q};
    else if (word == PRESET_W) bus.rdata = preset_q;
    else if (word == COUNT_W)  bus.rdata = count_q;
  end

  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    flag_d   = flag_q;

    case (state_q)
      S_IDLE: if (en) state_d = S_LOAD;
      S_LOAD: begin
        count_d = preset_q;
        state_d = S_CNT;
      end
      S_CNT: begin
        if (!en) begin
          state_d = S_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          count_d = 32'd0;
          state_d = S_INT;
          flag_d  = 1'b1;
        end
      end
      S_INT: begin
        if (auto_reload) begin
          state_d = S_LOAD;
          flag_d  = 1'b0;
        end else begin
          ctrl_d[0] = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // CPU writes are applied last so they win over any FSM update this edge.
    if (wr_ctrl) begin
      if (bus.byteen[0]) ctrl_d = bus.wdata[3:0];
      flag_d = 1'b0;
      if (!ctrl_d[0]) state_d = S_IDLE;
    end
    if (wr_preset) begin
      preset_d = merge_lanes(preset_q, bus.wdata, bus.byteen);
      flag_d   = 1'b0;
      state_d  = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      ctrl_q   <= 4'h0;
      preset_q <= 32'h0;
      count_q  <= 32'h0;
      flag_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
      irq_q    <= flag_d & ctrl_d[3];
    end
  end

  assign irq         = irq_q;
  assign dbg_state_o = state_q;

endmodule
